bit_selection_wr_port: RTL and testbench

// Write-side counterpart of the per-port read-data right-alignment logic in dpsram_block_4x512x20 simulation model.

---
 rtl/ram_cfg_pkg.sv | 52 +++++
 rtl/bit_selection_lane_enc.sv | 49 ++++
 rtl/bit_selection_wr_port.sv | 113 +++++++++++
 tb/tb_bit_selection_wr_port.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ram_cfg_pkg.sv
// rtl/ram_cfg_pkg.sv - RAM macro width configuration encodings and lane helpers
//
// Shared by the read-side alignment and write-side lane logic of the block RAM model.
// lane_width : data width W of one lane for a config (0 for the illegal config 0)
// lane_max   : highest legal lane index for a config
// lane_sel   : lane index L taken from the low address bits for a config
package ram_cfg_pkg;

  localparam logic [2:0] CONFIG_1BIT  = 3'd1;
  localparam logic [2:0] CONFIG_2BIT  = 3'd2;
  localparam logic [2:0] CONFIG_5BIT  = 3'd3;
  localparam logic [2:0] CONFIG_10BIT = 3'd4;
  localparam logic [2:0] CONFIG_20BIT = 3'd5;
  localparam logic [2:0] CONFIG_40BIT = 3'd6;
  localparam logic [2:0] CONFIG_80BIT = 3'd7;

  localparam int unsigned MACRO_W = 20;

  function automatic logic [4:0] lane_width(input logic [2:0] cfg);
    case (cfg)
      CONFIG_1BIT:  lane_width = 5'd1;
      CONFIG_2BIT:  lane_width = 5'd2;
      CONFIG_5BIT:  lane_width = 5'd5;
      CONFIG_10BIT: lane_width = 5'd10;
      CONFIG_20BIT,
      CONFIG_40BIT,
      CONFIG_80BIT: lane_width = 5'd20;
      default:      lane_width = 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] lane_max(input logic [2:0] cfg);
    case (cfg)
      CONFIG_1BIT:  lane_max = 5'd19;
      CONFIG_2BIT:  lane_max = 5'd9;
      CONFIG_5BIT:  lane_max = 5'd3;
      CONFIG_10BIT: lane_max = 5'd1;
      default:      lane_max = 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] lane_sel(input logic [2:0] cfg, input logic [4:0] addr);
    case (cfg)
      CONFIG_1BIT:  lane_sel = addr;
      CONFIG_2BIT:  lane_sel = {1'b0, addr[3:0]};
      CONFIG_5BIT:  lane_sel = {3'b0, addr[1:0]};
      CONFIG_10BIT: lane_sel = {4'b0, addr[0]};
      default:      lane_sel = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/bit_selection_lane_enc.sv
// rtl/bit_selection_lane_enc.sv - combinational lane decoder: legality, bit write enable, data replica
//
// Ports:
//   cfg        in  3   width config (CONFIG_* encoding)
//   addr       in  5   low address bits carrying the lane index
//   wrdata     in  20  right-aligned write data
//   legal      out 1   config nonzero and lane within range
//   bwe        out 20  per-bit write enable for the selected lane (0 when illegal)
//   wrdata_rep out 20  low W bits of wrdata replicated over the whole macro word
module bit_selection_lane_enc
  import ram_cfg_pkg::*;
(
  input  logic [2:0]  cfg,
  input  logic [4:0]  addr,
  input  logic [19:0] wrdata,
  output logic        legal,
  output logic [19:0] bwe,
  output logic [19:0] wrdata_rep
);

  logic [4:0] width;
  logic [4:0] lane;
  logic [9:0] lo;
  logic [9:0] hi;

  always_comb begin
    width = lane_width(cfg);
    lane  = lane_sel(cfg, addr);
    legal = (cfg != 3'd0) && (lane <= lane_max(cfg));
    lo    = 10'(lane) * 10'(width);
    hi    = lo + 10'(width);
    bwe   = '0;
    for (int i = 0; i < 20; i++) begin
      bwe[i] = legal && (10'(i) >= lo) && (10'(i) < hi);
    end
  end

  // Every lane gets the replica so the macro sees identical data regardless of mask.
  always_comb begin
    case (cfg)
      CONFIG_1BIT:  wrdata_rep = {20{wrdata[0]}};
      CONFIG_2BIT:  wrdata_rep = {10{wrdata[1:0]}};
      CONFIG_5BIT:  wrdata_rep = {4{wrdata[4:0]}};
      CONFIG_10BIT: wrdata_rep = {2{wrdata[9:0]}};
      default:      wrdata_rep = wrdata;
    endcase
  end

endmodule

// File: rtl/bit_selection_wr_port.sv
// rtl/bit_selection_wr_port.sv - write-side lane replication and bit enable for one RAM macro port
//
// Parameters: C_RAM macro index 1..4, PIPE latency 1 or 2 (2 adds an input capture stage).
// Ports:
//   clk_i, rst_i (async active-high)
//   input_config_i in 3, we_i in 1, addr_i in 16, wrdata_i in 20, err_clr_i in 1
//   we_o out 1, addr_o out 16, wrdata_o out 20, bwe_o out 20, err_o out 1 (sticky),
//   wr_cnt_o out 16 (saturating count of legal writes)
module bit_selection_wr_port
  import ram_cfg_pkg::*;
#(
  parameter int C_RAM = 1,
  parameter int PIPE  = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  input_config_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [19:0] wrdata_i,
  input  logic        err_clr_i,
  output logic        we_o,
  output logic [15:0] addr_o,
  output logic [19:0] wrdata_o,
  output logic [19:0] bwe_o,
  output logic        err_o,
  output logic [15:0] wr_cnt_o
);

  if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
    $error("bit_selection_wr_port: PIPE must be 1 or 2, got %0d", PIPE);
  end
  if (C_RAM < 1 || C_RAM > 4) begin : g_bad_cram
    $error("bit_selection_wr_port: C_RAM must be 1..4, got %0d", C_RAM);
  end

  logic [2:0]  s_cfg;
  logic        s_we;
  logic [15:0] s_addr;
  logic [19:0] s_data;

  if (PIPE == 2) begin : g_pipe2
    // Capture is unqualified: the stage simply delays the request by one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s_cfg  <= '0;
        s_we   <= 1'b0;
        s_addr <= '0;
        s_data <= '0;
      end else begin
        s_cfg  <= input_config_i;
        s_we   <= we_i;
        s_addr <= addr_i;
        s_data <= wrdata_i;
      end
    end
  end else begin : g_pipe1
    assign s_cfg  = input_config_i;
    assign s_we   = we_i;
    assign s_addr = addr_i;
    assign s_data = wrdata_i;
  end

  logic        legal;
  logic [19:0] bwe;
  logic [19:0] wrdata_rep;

  bit_selection_lane_enc u_lane_enc (
    .cfg        (s_cfg),
    .addr       (s_addr[4:0]),
    .wrdata     (s_data),
    .legal      (legal),
    .bwe        (bwe),
    .wrdata_rep (wrdata_rep)
  );

  logic wr_ok;
  logic wr_bad;

  assign wr_ok  = s_we && legal;
  assign wr_bad = s_we && !legal;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_o     <= 1'b0;
      addr_o   <= '0;
      wrdata_o <= '0;
      bwe_o    <= '0;
      err_o    <= 1'b0;
      wr_cnt_o <= '0;
    end else begin
      we_o  <= wr_ok;
      bwe_o <= wr_ok ? bwe : 20'd0;
      // Data is only updated on a legal write so the macro bus stays quiet otherwise.
      if (wr_ok) begin
        wrdata_o <= wrdata_rep;
      end
      if (s_we) begin
        addr_o <= s_addr;
      end
      // A new error in the same cycle beats the clear.
      if (wr_bad) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
      if (wr_ok && wr_cnt_o != 16'hFFFF) begin
        wr_cnt_o <= wr_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bit_selection_wr_port.sv
// tb/tb_bit_selection_wr_port.sv - directed self-checking bench for bit_selection_wr_port (PIPE 1 and 2)
module tb_bit_selection_wr_port;

  logic        clk;
  logic        rst;
  logic [2:0]  cfg;
  logic        we;
  logic [15:0] addr;
  logic [19:0] data;
  logic        clr;

  logic        p1_we, p2_we;
  logic [15:0] p1_addr, p2_addr;
  logic [19:0] p1_wrdata, p2_wrdata;
  logic [19:0] p1_bwe, p2_bwe;
  logic        p1_err, p2_err;
  logic [15:0] p1_cnt, p2_cnt;

  int n_checks = 0;
  int n_errors = 0;

  bit_selection_wr_port #(.C_RAM(1), .PIPE(1)) u_p1 (
    .clk_i(clk), .rst_i(rst), .input_config_i(cfg), .we_i(we), .addr_i(addr),
    .wrdata_i(data), .err_clr_i(clr), .we_o(p1_we), .addr_o(p1_addr),
    .wrdata_o(p1_wrdata), .bwe_o(p1_bwe), .err_o(p1_err), .wr_cnt_o(p1_cnt)
  );

  bit_selection_wr_port #(.C_RAM(2), .PIPE(2)) u_p2 (
    .clk_i(clk), .rst_i(rst), .input_config_i(cfg), .we_i(we), .addr_i(addr),
    .wrdata_i(data), .err_clr_i(clr), .we_o(p2_we), .addr_o(p2_addr),
    .wrdata_o(p2_wrdata), .bwe_o(p2_bwe), .err_o(p2_err), .wr_cnt_o(p2_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One-cycle write presented at a negedge; returns at the next negedge with we low again.
  task automatic drive_write(input logic [2:0] c, input logic [15:0] a, input logic [19:0] d);
    cfg  = c;
    addr = a;
    data = d;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  c;
    logic [15:0] a;
    logic [19:0] d;
    logic [19:0] bwe;
    logic [19:0] rep;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{3'd1, 16'h0007, 20'h00001, 20'h00080, 20'hFFFFF};
    vecs[1] = '{3'd3, 16'h0002, 20'h00015, 20'h07C00, 20'hAD6B5};
    vecs[2] = '{3'd4, 16'h0001, 20'h003FF, 20'hFFC00, 20'hFFFFF};
    vecs[3] = '{3'd1, 16'h0013, 20'h00000, 20'h80000, 20'h00000};
    vecs[4] = '{3'd2, 16'h0009, 20'h00002, 20'hC0000, 20'hAAAAA};
    vecs[5] = '{3'd3, 16'h0003, 20'h0000A, 20'hF8000, 20'h5294A};
    vecs[6] = '{3'd1, 16'hFFE3, 20'hFFFFE, 20'h00008, 20'h00000};
    vecs[7] = '{3'd5, 16'h0000, 20'h12345, 20'hFFFFF, 20'h12345};
    vecs[8] = '{3'd7, 16'hFFFF, 20'hABCDE, 20'hFFFFF, 20'hABCDE};

    rst = 1'b1; cfg = 3'd0; we = 1'b0; addr = '0; data = '0; clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_p1_we", 32'(p1_we), 32'd0);
    chk("rst_p1_bwe", 32'(p1_bwe), 32'd0);
    chk("rst_p1_wrdata", 32'(p1_wrdata), 32'd0);
    chk("rst_p1_addr", 32'(p1_addr), 32'd0);
    chk("rst_p1_err", 32'(p1_err), 32'd0);
    chk("rst_p1_cnt", 32'(p1_cnt), 32'd0);
    chk("rst_p2_we", 32'(p2_we), 32'd0);
    chk("rst_p2_cnt", 32'(p2_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      drive_write(vecs[i].c, vecs[i].a, vecs[i].d);
      chk($sformatf("vec%0d_we", i), 32'(p1_we), 32'd1);
      chk($sformatf("vec%0d_bwe", i), 32'(p1_bwe), 32'(vecs[i].bwe));
      chk($sformatf("vec%0d_wrdata", i), 32'(p1_wrdata), 32'(vecs[i].rep));
    end
    chk("vec_cnt", 32'(p1_cnt), 32'd9);
    chk("vec_err", 32'(p1_err), 32'd0);

    // Idle: strobe and mask drop, data and address hold.
    @(negedge clk);
    chk("idle_we", 32'(p1_we), 32'd0);
    chk("idle_bwe", 32'(p1_bwe), 32'd0);
    chk("idle_wrdata", 32'(p1_wrdata), 32'hABCDE);
    chk("idle_addr", 32'(p1_addr), 32'hFFFF);

    // Illegal 2-bit lane 10.
    drive_write(3'd2, 16'h000A, 20'h00001);
    chk("ill2_we", 32'(p1_we), 32'd0);
    chk("ill2_bwe", 32'(p1_bwe), 32'd0);
    chk("ill2_wrdata", 32'(p1_wrdata), 32'hABCDE);
    chk("ill2_err", 32'(p1_err), 32'd1);
    chk("ill2_cnt", 32'(p1_cnt), 32'd9);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_err", 32'(p1_err), 32'd0);

    // Config 0 write together with a clear: set wins.
    clr = 1'b1;
    drive_write(3'd0, 16'h0000, 20'h00001);
    clr = 1'b0;
    chk("setclr_err", 32'(p1_err), 32'd1);
    chk("cfg0_we", 32'(p1_we), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr2_err", 32'(p1_err), 32'd0);

    // 1-bit lane 20 is one past the last legal lane.
    drive_write(3'd1, 16'h0014, 20'h00001);
    chk("ill1_we", 32'(p1_we), 32'd0);
    chk("ill1_err", 32'(p1_err), 32'd1);

    // Burst of 20 writes, 40-bit config, observed on the PIPE=2 instance.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cfg = 3'd6; addr = 16'h0000; data = 20'h5A5A5;
    for (int c = 0; c < 22; c++) begin
      we = (c < 20);
      @(negedge clk);
      chk($sformatf("burst%0d_p2_we", c), 32'(p2_we), 32'((c >= 1) && (c <= 20)));
      chk($sformatf("burst%0d_p2_bwe", c), 32'(p2_bwe),
          ((c >= 1) && (c <= 20)) ? 32'hFFFFF : 32'd0);
    end
    we = 1'b0;
    chk("burst_p2_cnt", 32'(p2_cnt), 32'd20);
    chk("burst_p2_wrdata", 32'(p2_wrdata), 32'h5A5A5);

    // Reset mid-burst with err set.
    drive_write(3'd0, 16'h0000, 20'h0);
    @(negedge clk);
    chk("pre_rst_p2_err", 32'(p2_err), 32'd1);
    cfg = 3'd5; data = 20'h11111; we = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_p1_we", 32'(p1_we), 32'd0);
    chk("mid_rst_p1_bwe", 32'(p1_bwe), 32'd0);
    chk("mid_rst_p2_we", 32'(p2_we), 32'd0);
    chk("mid_rst_p2_err", 32'(p2_err), 32'd0);
    chk("mid_rst_p1_cnt", 32'(p1_cnt), 32'd0);
    we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive_write(3'd1, 16'h0000, 20'h00001);
    chk("post_rst_p1_we", 32'(p1_we), 32'd1);
    chk("post_rst_p1_bwe", 32'(p1_bwe), 32'h00001);
    chk("post_rst_p2_we0", 32'(p2_we), 32'd0);
    @(negedge clk);
    chk("post_rst_p2_we1", 32'(p2_we), 32'd1);
    chk("post_rst_p2_bwe", 32'(p2_bwe), 32'h00001);
    chk("post_rst_p1_idle", 32'(p1_we), 32'd0);

    // Counter saturation.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cfg = 3'd5; we = 1'b1;
    repeat (65534) @(negedge clk);
    chk("sat_p1_fffe", 32'(p1_cnt), 32'hFFFE);
    repeat (3) @(negedge clk);
    we = 1'b0;
    chk("sat_p1_ffff", 32'(p1_cnt), 32'hFFFF);
    @(negedge clk);
    chk("sat_p2_ffff", 32'(p2_cnt), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
